// File: rtl/ma_vrf_str.sv
// ma_vrf_str: STR.V store datamover. Prefetches consecutive VRF rows through the arbiter read
// port into a small FIFO and drains them to DDR4 as AXI4 INCR bursts that never cross 4 KB.
module ma_vrf_str #(
  parameter int unsigned DDR4_ADDRWIDTH = 36,
  parameter int unsigned VRF_ADDRWIDTH  = 10,
  parameter int unsigned VRF_DATAWIDTH  = 1024,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [VRF_ADDRWIDTH-1:0]    vrf_addr_i,
  input  logic [DDR4_ADDRWIDTH-1:0]   ddr_addr_i,
  input  logic [7:0]                  num_m1_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        rd_req_o,
  output logic [VRF_ADDRWIDTH-1:0]    rd_addr_o,
  input  logic                        rd_gnt_i,
  input  logic [VRF_DATAWIDTH-1:0]    rd_data_i,
  output logic [DDR4_ADDRWIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [VRF_DATAWIDTH-1:0]    m_axi_wdata,
  output logic [VRF_DATAWIDTH/8-1:0]  m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] LP_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StDone} state_e;

  state_e r_state, w_state_d;

  logic [VRF_ADDRWIDTH-1:0]  r_rd_addr;
  logic [8:0]                r_rows_req;
  logic [8:0]                r_total;
  logic [DDR4_ADDRWIDTH-1:0] r_awaddr;
  logic [8:0]                r_rows_left;
  logic [7:0]                r_beat_cnt;
  logic                      r_err;

  logic [VRF_DATAWIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [PW:0]               r_count;

  logic       w_busy, w_start, w_push, w_pop, w_wvalid, w_wlast, w_bdone, w_awvalid;
  logic [5:0] w_room;
  logic [8:0] w_beats, w_rows_after;
  logic [7:0] w_awlen;
  logic       w_unused;

  // Sub-beat address bits are ignored; the AXI address is always beat aligned.
  assign w_unused = ^ddr_addr_i[6:0];

  assign w_busy    = (r_state == StAw) || (r_state == StW) || (r_state == StB);
  assign w_start   = start_i && (r_state == StIdle);
  // Beats left before the next 4 KB page; also caps the burst at 32 beats of 128 bytes.
  assign w_room    = 6'd32 - {1'b0, r_awaddr[11:7]};
  assign w_beats   = (r_rows_left < 9'(w_room)) ? r_rows_left : 9'(w_room);
  assign w_awlen   = 8'(w_beats - 9'd1);
  assign w_rows_after = r_rows_left - w_beats;

  assign rd_req_o  = w_busy && (r_rows_req < r_total) && (r_count < LP_FULL);
  assign rd_addr_o = r_rd_addr;
  assign w_push    = rd_req_o && rd_gnt_i;

  assign w_awvalid = (r_state == StAw);
  assign w_wvalid  = (r_state == StW) && (r_count != '0);
  assign w_pop     = w_wvalid && m_axi_wready;
  assign w_wlast   = w_wvalid && (r_beat_cnt == w_awlen);
  assign w_bdone   = (r_state == StB) && m_axi_bvalid;

  assign busy_o        = w_busy;
  assign done_o        = (r_state == StDone);
  assign err_o         = r_err;
  assign m_axi_awvalid = w_awvalid;
  assign m_axi_awaddr  = w_awvalid ? r_awaddr : '0;
  assign m_axi_awlen   = w_awvalid ? w_awlen : '0;
  assign m_axi_awsize  = w_awvalid ? 3'd7 : '0;
  assign m_axi_awburst = w_awvalid ? 2'b01 : '0;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_wdata   = w_wvalid ? r_mem[r_rptr] : '0;
  assign m_axi_wstrb   = {(VRF_DATAWIDTH/8){w_wvalid}};
  assign m_axi_wlast   = w_wlast;
  assign m_axi_bready  = (r_state == StB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (start_i) w_state_d = StAw;
      StAw:   if (m_axi_awready) w_state_d = StW;
      StW:    if (w_pop && w_wlast) w_state_d = StB;
      StB:    if (m_axi_bvalid) w_state_d = (w_rows_after != '0) ? StAw : StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr   <= '0;
      r_rows_req  <= '0;
      r_total     <= '0;
      r_awaddr    <= '0;
      r_rows_left <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else if (w_start) begin
      r_rd_addr   <= vrf_addr_i;
      r_rows_req  <= '0;
      r_total     <= 9'(num_m1_i) + 9'd1;
      r_awaddr    <= {ddr_addr_i[DDR4_ADDRWIDTH-1:7], 7'd0};
      r_rows_left <= 9'(num_m1_i) + 9'd1;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_rd_addr  <= r_rd_addr + VRF_ADDRWIDTH'(1);
        r_rows_req <= r_rows_req + 9'd1;
      end
      if (w_pop) begin
        r_beat_cnt <= w_wlast ? 8'd0 : r_beat_cnt + 8'd1;
      end
      // Burst bookkeeping only advances once the response is in, so w_beats stays stable.
      if (w_bdone) begin
        r_awaddr    <= r_awaddr + (DDR4_ADDRWIDTH'(w_beats) << 7);
        r_rows_left <= w_rows_after;
        if (m_axi_bresp != 2'b00) r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rd_data_i;
  end

endmodule

// File: tb/tb_ma_vrf_str.sv
// Bench for ma_vrf_str: randomized arbiter/AXI slave, burst model derived from the 4 KB and
// 32-beat split rules, per-scenario checks of AW/W traffic, ordering, errors and reset.
module tb_ma_vrf_str;
  localparam int unsigned AW = 36;
  localparam int unsigned VA = 10;
  localparam int unsigned DW = 1024;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [VA-1:0] vrf_addr_i = '0;
  logic [AW-1:0] ddr_addr_i = '0;
  logic [7:0] num_m1_i = '0;
  logic busy_o, done_o, err_o, rd_req_o;
  logic [VA-1:0] rd_addr_o;
  logic rd_gnt_i = 1'b0;
  logic [DW-1:0] rd_data_i;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_awvalid;
  logic m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid;
  logic m_axi_wready = 1'b0;
  logic [1:0] m_axi_bresp = 2'b00;
  logic m_axi_bvalid = 1'b0;
  logic m_axi_bready;

  always #5 clk = ~clk;

  ma_vrf_str dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .vrf_addr_i(vrf_addr_i),
    .ddr_addr_i(ddr_addr_i), .num_m1_i(num_m1_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
    .rd_data_i(rd_data_i), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int total = 0;
  int bad = 0;

  // Slave / arbiter behaviour knobs
  logic [31:0] salt = '0;
  int gnt_mode = 0;
  int aw_pct = 100, w_pct = 100, b_pct = 100;
  int err_burst = -1;

  function automatic logic [DW-1:0] mk_data(input logic [VA-1:0] a, input logic [31:0] s);
    logic [DW-1:0] d;
    d = '0;
    d[VA-1:0] = a;
    d[63:32] = s;
    d[DW-1:DW-32] = s;
    return d;
  endfunction

  assign rd_data_i = rd_gnt_i ? mk_data(rd_addr_o, salt) : '0;

  // Observed traffic
  logic [AW-1:0] q_awaddr[$];
  logic [7:0] q_awlen[$];
  logic [DW-1:0] q_wdata[$];
  logic q_wlast[$];
  int cyc = 0, pend_b = 0, occ = 0;
  int n_aw = 0, n_b = 0, n_gnt = 0, n_wbeat = 0, n_done = 0;
  int viol_full = 0, viol_stable = 0, viol_outst = 0, viol_const = 0, viol_done_busy = 0;
  int max_pref = 0;
  logic err_at_done = 1'b0;
  logic prev_wait = 1'b0;
  logic [VA-1:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    rd_gnt_i = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? (cyc % 3 == 0)
             : ($urandom_range(1, 0) == 1);
    m_axi_awready = ($urandom_range(99, 0) < aw_pct);
    m_axi_wready  = ($urandom_range(99, 0) < w_pct);
    m_axi_bvalid  = (pend_b > 0) && ($urandom_range(99, 0) < b_pct);
    m_axi_bresp   = (n_b == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (!rst_n) begin
      pend_b = 0;
      prev_wait = 1'b0;
    end else begin
      occ = n_gnt - n_wbeat;
      if (rd_req_o && occ >= FD) viol_full++;
      if (prev_wait && (!rd_req_o || rd_addr_o != prev_addr)) viol_stable++;
      prev_wait = rd_req_o && !rd_gnt_i;
      prev_addr = rd_addr_o;
      if (m_axi_awvalid && (m_axi_awsize != 3'd7 || m_axi_awburst != 2'b01)) viol_const++;
      if (m_axi_wvalid && m_axi_wstrb != '1) viol_const++;
      if (m_axi_awvalid && m_axi_awready) begin
        if (n_aw != n_b) viol_outst++;
        q_awaddr.push_back(m_axi_awaddr);
        q_awlen.push_back(m_axi_awlen);
        n_aw++;
      end
      if (rd_req_o && rd_gnt_i) n_gnt++;
      if (m_axi_wvalid && m_axi_wready) begin
        q_wdata.push_back(m_axi_wdata);
        q_wlast.push_back(m_axi_wlast);
        n_wbeat++;
        if (m_axi_wlast) pend_b++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        n_b++;
        pend_b--;
      end
      if (done_o) begin
        n_done++;
        err_at_done = err_o;
        if (busy_o) viol_done_busy++;
      end
      if (n_gnt - n_wbeat > max_pref) max_pref = n_gnt - n_wbeat;
    end
  end

  // Reference burst list from the split rules
  logic [AW-1:0] e_addr[$];
  logic [7:0] e_len[$];
  logic e_last[$];

  task automatic build_model(input logic [AW-1:0] ddr, input int n);
    longint a;
    int rem, room, b;
    e_addr.delete(); e_len.delete(); e_last.delete();
    a = longint'(ddr) - (longint'(ddr) % 128);
    rem = n;
    while (rem > 0) begin
      room = 32 - int'((a % 4096) / 128);
      b = (rem < room) ? rem : room;
      e_addr.push_back(AW'(a));
      e_len.push_back(8'(b - 1));
      for (int k = 0; k < b; k++) e_last.push_back(k == b - 1);
      a += longint'(b) * 128;
      rem -= b;
    end
  endtask

  task automatic reset_mon();
    q_awaddr.delete(); q_awlen.delete(); q_wdata.delete(); q_wlast.delete();
    n_aw = 0; n_b = 0; n_gnt = 0; n_wbeat = 0; n_done = 0; pend_b = 0;
    err_at_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (n_done != 0) break;
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic run_cmd(input logic [VA-1:0] vrf, input logic [AW-1:0] ddr,
                         input logic [7:0] num, input int budget);
    reset_mon();
    @(negedge clk);
    vrf_addr_i = vrf; ddr_addr_i = ddr; num_m1_i = num; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(budget);
  endtask

  task automatic test_reset();
    logic [66:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    outs = {busy_o, done_o, err_o, rd_req_o, rd_addr_o, m_axi_awaddr, m_axi_awlen,
            m_axi_awsize, m_axi_awburst, m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_ctrl got=%0h want=0", outs); end
    total++;
    if (m_axi_wdata !== '0 || m_axi_wstrb !== '0) begin
      bad++; $display("FAIL reset_wchan got=%0h want=0", m_axi_wstrb);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if ({busy_o, rd_req_o, m_axi_awvalid, done_o} !== 4'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b want=0000",
                      {busy_o, rd_req_o, m_axi_awvalid, done_o});
    end
  endtask

  task automatic test_transfer();
    for (int c = 0; c < 8; c++) begin
      logic [VA-1:0] vrf;
      logic [AW-1:0] ddr;
      logic [7:0] num;
      gnt_mode = 0; aw_pct = 100; w_pct = 100; b_pct = 100; salt = '0;
      case (c)
        0: begin vrf = 10'd5;    ddr = 36'h1000; num = 8'd0;   end
        1: begin vrf = 10'd0;    ddr = 36'h0;    num = 8'd7;   end
        2: begin vrf = 10'd33;   ddr = 36'hF80;  num = 8'd3;   end
        3: begin vrf = 10'd1020; ddr = 36'h0;    num = 8'd255; end
        default: begin
          vrf = VA'($urandom_range(1023, 0));
          ddr = AW'({$urandom(), $urandom()});
          num = 8'($urandom_range(255, 0));
          salt = $urandom();
          gnt_mode = 2; aw_pct = 60; w_pct = 60; b_pct = 60;
        end
      endcase
      build_model(ddr, int'(num) + 1);
      run_cmd(vrf, ddr, num, 4000);
      total++;
      if (n_done !== 1) begin bad++; $display("FAIL xfer%0d done got=%0d want=1", c, n_done); end
      total++;
      if (err_at_done !== 1'b0) begin bad++; $display("FAIL xfer%0d err got=1 want=0", c); end
      total++;
      if (q_awaddr.size() != e_addr.size()) begin
        bad++; $display("FAIL xfer%0d nburst got=%0d want=%0d", c, q_awaddr.size(), e_addr.size());
      end
      for (int i = 0; i < e_addr.size() && i < q_awaddr.size(); i++) begin
        total++;
        if (q_awaddr[i] !== e_addr[i] || q_awlen[i] !== e_len[i]) begin
          bad++; $display("FAIL xfer%0d aw%0d got=%0h/%0d want=%0h/%0d", c, i, q_awaddr[i],
                          q_awlen[i], e_addr[i], e_len[i]);
        end
      end
      total++;
      if (q_wdata.size() != int'(num) + 1) begin
        bad++; $display("FAIL xfer%0d nbeat got=%0d want=%0d", c, q_wdata.size(), int'(num) + 1);
      end
      for (int k = 0; k <= int'(num) && k < q_wdata.size(); k++) begin
        total++;
        if (q_wdata[k] !== mk_data(VA'((int'(vrf) + k) % 1024), salt) || q_wlast[k] !== e_last[k])
        begin
          bad++; $display("FAIL xfer%0d beat%0d got=%0h/%b want=%0h/%b", c, k, q_wdata[k][VA-1:0],
                          q_wlast[k], VA'((int'(vrf) + k) % 1024), e_last[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    gnt_mode = 1; aw_pct = 50; w_pct = 40; b_pct = 50;
    for (int c = 0; c < 3; c++) begin
      logic [VA-1:0] vrf;
      logic [7:0] num;
      vrf = VA'($urandom_range(1023, 0));
      num = 8'($urandom_range(60, 8));
      salt = $urandom();
      run_cmd(vrf, 36'h3C00, num, 6000);
      total++;
      if (n_done !== 1 || q_wdata.size() != int'(num) + 1) begin
        bad++; $display("FAIL bp%0d done/beats got=%0d/%0d want=1/%0d", c, n_done, q_wdata.size(),
                        int'(num) + 1);
      end
      for (int k = 0; k < q_wdata.size(); k++) begin
        total++;
        if (q_wdata[k] !== mk_data(VA'((int'(vrf) + k) % 1024), salt)) begin
          bad++; $display("FAIL bp%0d order%0d got=%0h want=%0h", c, k, q_wdata[k][VA-1:0],
                          VA'((int'(vrf) + k) % 1024));
        end
      end
    end
    total++;
    if (max_pref > FD) begin bad++; $display("FAIL prefetch_depth got=%0d want<=%0d", max_pref, FD); end
    total++;
    if (viol_full !== 0) begin bad++; $display("FAIL req_when_full got=%0d want=0", viol_full); end
    total++;
    if (viol_stable !== 0) begin bad++; $display("FAIL req_stable got=%0d want=0", viol_stable); end
    gnt_mode = 0; aw_pct = 100; w_pct = 100; b_pct = 100;
  endtask

  task automatic test_error();
    salt = 32'hE4404;
    err_burst = 1;
    run_cmd(10'd200, 36'h0, 8'd95, 2000);
    err_burst = -1;
    total++;
    if (n_aw !== 3) begin bad++; $display("FAIL err_bursts got=%0d want=3", n_aw); end
    total++;
    if (n_done !== 1 || err_at_done !== 1'b1) begin
      bad++; $display("FAIL err_at_done got=%0d/%b want=1/1", n_done, err_at_done);
    end
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_o); end
    total++;
    if (n_wbeat !== 96) begin bad++; $display("FAIL err_beats got=%0d want=96", n_wbeat); end
    run_cmd(10'd0, 36'h80, 8'd1, 500);
    total++;
    if (n_done !== 1 || err_at_done !== 1'b0) begin
      bad++; $display("FAIL err_cleared got=%0d/%b want=1/0", n_done, err_at_done);
    end
  endtask

  task automatic test_start_while_busy();
    reset_mon();
    salt = 32'h1234_5678;
    @(negedge clk);
    vrf_addr_i = 10'd100; ddr_addr_i = 36'h2000; num_m1_i = 8'd15; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_during_cmd got=%b want=1", busy_o); end
    vrf_addr_i = 10'd7; ddr_addr_i = 36'h40000; num_m1_i = 8'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(500);
    total++;
    if (n_done !== 1 || n_aw !== 1) begin
      bad++; $display("FAIL busy_start done/aw got=%0d/%0d want=1/1", n_done, n_aw);
    end
    total++;
    if (q_awaddr.size() < 1 || q_awaddr[0] !== 36'h2000 || q_awlen[0] !== 8'd15) begin
      bad++; $display("FAIL busy_start_aw got=%0d bursts want=0x2000/15", q_awaddr.size());
    end
    total++;
    if (q_wdata.size() != 16) begin bad++; $display("FAIL busy_start_beats got=%0d want=16", q_wdata.size()); end
    for (int k = 0; k < q_wdata.size(); k++) begin
      total++;
      if (q_wdata[k] !== mk_data(VA'(100 + k), salt)) begin
        bad++; $display("FAIL busy_start_data%0d got=%0h want=%0h", k, q_wdata[k][VA-1:0], 100 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [66:0] outs;
    reset_mon();
    salt = 32'h0;
    @(negedge clk);
    vrf_addr_i = 10'd0; ddr_addr_i = 36'h0; num_m1_i = 8'd63; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 200 && n_wbeat < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {busy_o, done_o, err_o, rd_req_o, rd_addr_o, m_axi_awaddr, m_axi_awlen,
            m_axi_awsize, m_axi_awburst, m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready};
    total++;
    if (outs !== '0 || m_axi_wdata !== '0) begin
      bad++; $display("FAIL midreset_outs got=%0h want=0", outs);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    total++;
    if (n_done !== 0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL midreset_nodone got=%0d/%b want=0/0", n_done, busy_o);
    end
    run_cmd(10'd9, 36'h500, 8'd0, 200);
    total++;
    if (n_done !== 1 || q_wdata.size() != 1 || q_wdata[0] !== mk_data(10'd9, salt)) begin
      bad++; $display("FAIL midreset_recover got=%0d/%0d want=1/1", n_done, q_wdata.size());
    end
  endtask

  task automatic test_protocol();
    total++;
    if (viol_outst !== 0) begin bad++; $display("FAIL aw_before_b got=%0d want=0", viol_outst); end
    total++;
    if (viol_const !== 0) begin bad++; $display("FAIL axi_constants got=%0d want=0", viol_const); end
    total++;
    if (viol_done_busy !== 0) begin bad++; $display("FAIL done_with_busy got=%0d want=0", viol_done_busy); end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_backpressure();
    test_error();
    test_start_while_busy();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
